// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM RAM port arbiter.
package mem_arb_pkg;

    // Arbiter FSM state encoding.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusyIf  = 2'd1,
        StBusyMem = 2'd2,
        StAck     = 2'd3
    } arb_state_e;

    // Latency counter width and the largest RAM latency it can count.
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned LAT_MAX = 15;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one fixed-latency RAM port.
// MEM has fixed priority; a fetch dropped mid-access completes silently.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_ack,
    output logic [DW-1:0] mem_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          pipe_stall
);

    // Counter load value; LAT is legal only in 1..LAT_MAX so it fits in CNT_W bits.
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
    logic             ram_en_q, ram_en_d;
    logic             ram_we_q, ram_we_d;
    logic [AW-1:0]    ram_addr_q, ram_addr_d;
    logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
    logic             if_ack_q, if_ack_d;
    logic             mem_ack_q, mem_ack_d;
    logic [DW-1:0]    if_rdata_q, if_rdata_d;
    logic [DW-1:0]    mem_rdata_q, mem_rdata_d;

    // Next-state: grant in IDLE, count down the RAM latency, capture data, ack.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    state_d     = StBusyMem;
                    ram_en_d    = 1'b1;
                    ram_we_d    = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    cnt_d       = LAT_CNT;
                end else if (if_req) begin
                    state_d    = StBusyIf;
                    ram_en_d   = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = if_addr;
                    cnt_d      = LAT_CNT;
                end
            end
            StBusyIf: begin
                // A dropped request at any point cancels the fetch for good.
                if (!if_req) begin
                    abort_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = StAck;
                    if (if_req && !abort_q) begin
                        if_rdata_d = ram_rdata;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StBusyMem: begin
                if (cnt_q == '0) begin
                    state_d   = StAck;
                    mem_ack_d = 1'b1;
                    if (!ram_we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck: begin
                // No grant here: the acked requester may still show req this cycle.
                state_d = StIdle;
                abort_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign pipe_stall = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule
